// File: rtl/sd_pkg.sv
// Shared definitions for the SD card command path: owner codes, tie-break modes,
// arbiter FSM states and the command indices the host FSMs use.
package sd_pkg;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_R0   = 2'b01;
    localparam logic [1:0] OWN_R1   = 2'b10;

    localparam int PRIO_P0 = 0;
    localparam int PRIO_P1 = 1;
    localparam int PRIO_RR = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1,
        ST_DRAIN
    } arb_state_t;

    localparam logic [5:0] CMD13 = 6'd13;
    localparam logic [5:0] CMD24 = 6'd24;

    function automatic logic [1:0] owner_code(input logic idx);
        return idx ? OWN_R1 : OWN_R0;
    endfunction

endpackage

// File: rtl/sd_cmd_arb_pick.sv
// Combinational grant selector: picks which requesting port wins the engine,
// using fixed priority or round-robin against the last granted port.
module sd_cmd_arb_pick
    import sd_pkg::*;
#(
    parameter int PRIORITY = PRIO_P0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       idx
);

    always_comb begin
        idx = 1'b0;
        case (req)
            2'b01: idx = 1'b0;
            2'b10: idx = 1'b1;
            2'b11: begin
                if (PRIORITY == PRIO_P1) begin
                    idx = 1'b1;
                end else if (PRIORITY == PRIO_RR) begin
                    idx = ~last;
                end else begin
                    idx = 1'b0;
                end
            end
            default: idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Two-port ownership arbiter in front of the single SD command engine: forwards
// only the owner's commands, shields the other port, and polices misuse.
module sd_cmd_arbiter
    import sd_pkg::*;
#(
    parameter int          PRIORITY   = PRIO_P0,
    parameter logic [23:0] HOLD_MAX   = 24'd4000000,
    parameter logic [15:0] SLOWCLKDIV = 16'd192
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        r0_req,
    output logic        r0_gnt,
    input  logic        r0_start,
    input  logic [15:0] r0_precnt,
    input  logic [5:0]  r0_cmd,
    input  logic [31:0] r0_arg,
    input  logic [15:0] r0_clkdiv,
    output logic        r0_busy,
    output logic        r0_done,
    output logic        r0_timeout,
    output logic        r0_syntaxe,
    output logic [31:0] r0_resparg,
    input  logic        r1_req,
    output logic        r1_gnt,
    input  logic        r1_start,
    input  logic [15:0] r1_precnt,
    input  logic [5:0]  r1_cmd,
    input  logic [31:0] r1_arg,
    input  logic [15:0] r1_clkdiv,
    output logic        r1_busy,
    output logic        r1_done,
    output logic        r1_timeout,
    output logic        r1_syntaxe,
    output logic [31:0] r1_resparg,
    output logic        start,
    output logic [15:0] precnt,
    output logic [5:0]  cmd,
    output logic [31:0] arg,
    output logic [15:0] clkdiv,
    input  logic        busy,
    input  logic        done,
    input  logic        timeout,
    input  logic        syntaxe,
    input  logic [31:0] resparg,
    output logic [1:0]  owner,
    output logic        revoked,
    output logic        proto_err
);

    arb_state_t  state;
    logic        inflight;
    logic        last;
    logic [23:0] hold_cnt;
    logic        pick_idx;

    logic        own_idx;
    logic        own_req;
    logic        own_start;
    logic        other_start;
    logic [15:0] own_precnt;
    logic [5:0]  own_cmd;
    logic [31:0] own_arg;
    logic [15:0] own_clkdiv;
    logic        eng_idle;
    logic        owning;
    logic        fwd;
    logic [23:0] hold_next;
    logic        hold_hit;

    sd_cmd_arb_pick #(.PRIORITY(PRIORITY)) u_pick (
        .req  ({r1_req, r0_req}),
        .last (last),
        .idx  (pick_idx)
    );

    // The registered grant doubles as the owner index, so DRAIN keeps the same mux.
    always_comb begin
        own_idx     = r1_gnt;
        own_req     = own_idx ? r1_req    : r0_req;
        own_start   = own_idx ? r1_start  : r0_start;
        other_start = own_idx ? r0_start  : r1_start;
        own_precnt  = own_idx ? r1_precnt : r0_precnt;
        own_cmd     = own_idx ? r1_cmd    : r0_cmd;
        own_arg     = own_idx ? r1_arg    : r0_arg;
        own_clkdiv  = own_idx ? r1_clkdiv : r0_clkdiv;
    end

    assign eng_idle  = !busy && !inflight;
    assign owning    = (state == ST_OWN0) || (state == ST_OWN1);
    assign fwd       = owning && own_start && eng_idle;
    assign hold_next = hold_cnt + 24'd1;
    assign hold_hit  = (HOLD_MAX != 24'd0) && eng_idle && !own_start && (hold_next == HOLD_MAX);

    // inflight covers the gap between a forwarded start and the engine raising busy.
    assign r0_busy    = r0_gnt ? (busy | start | inflight) : 1'b1;
    assign r1_busy    = r1_gnt ? (busy | start | inflight) : 1'b1;
    assign r0_done    = done    & r0_gnt;
    assign r1_done    = done    & r1_gnt;
    assign r0_timeout = timeout & r0_gnt;
    assign r1_timeout = timeout & r1_gnt;
    assign r0_syntaxe = syntaxe & r0_gnt;
    assign r1_syntaxe = syntaxe & r1_gnt;
    assign r0_resparg = r0_gnt ? resparg : 32'd0;
    assign r1_resparg = r1_gnt ? resparg : 32'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            start     <= 1'b0;
            precnt    <= 16'd0;
            cmd       <= 6'd0;
            arg       <= 32'd0;
            clkdiv    <= SLOWCLKDIV;
            owner     <= OWN_NONE;
            revoked   <= 1'b0;
            proto_err <= 1'b0;
            hold_cnt  <= 24'd0;
            inflight  <= 1'b0;
            last      <= 1'b1;
        end else begin
            start   <= 1'b0;
            revoked <= 1'b0;

            if (fwd) begin
                inflight <= 1'b1;
            end else if (busy || done) begin
                inflight <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    clkdiv   <= SLOWCLKDIV;
                    hold_cnt <= 24'd0;
                    if (r0_start || r1_start) begin
                        proto_err <= 1'b1;
                    end
                    if (r0_req || r1_req) begin
                        state  <= pick_idx ? ST_OWN1 : ST_OWN0;
                        r0_gnt <= !pick_idx;
                        r1_gnt <= pick_idx;
                        owner  <= owner_code(pick_idx);
                    end
                end

                ST_OWN0, ST_OWN1: begin
                    clkdiv <= own_clkdiv;
                    if (other_start || (own_start && !eng_idle)) begin
                        proto_err <= 1'b1;
                    end
                    if (fwd) begin
                        start    <= 1'b1;
                        precnt   <= own_precnt;
                        cmd      <= own_cmd;
                        arg      <= own_arg;
                        hold_cnt <= 24'd0;
                    end else if (eng_idle) begin
                        hold_cnt <= hold_next;
                    end
                    // A start issued together with the request drop is still forwarded above.
                    if (!own_req) begin
                        state <= ST_DRAIN;
                    end else if (hold_hit) begin
                        state   <= ST_DRAIN;
                        revoked <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    clkdiv <= own_clkdiv;
                    if (r0_start || r1_start) begin
                        proto_err <= 1'b1;
                    end
                    if (eng_idle) begin
                        state  <= ST_IDLE;
                        r0_gnt <= 1'b0;
                        r1_gnt <= 1'b0;
                        owner  <= OWN_NONE;
                        last   <= own_idx;
                        clkdiv <= SLOWCLKDIV;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter with a behavioural engine responder and
// a round-robin ownership model; PRIORITY=2 and HOLD_MAX=16 in this build.
module tb_sd_cmd_arbiter;
    import sd_pkg::*;

    localparam logic [15:0] SLOW = 16'd192;

    logic        clk;
    logic        rstn;
    logic        r0_req, r0_gnt, r0_start, r0_busy, r0_done, r0_timeout, r0_syntaxe;
    logic [15:0] r0_precnt, r0_clkdiv;
    logic [5:0]  r0_cmd;
    logic [31:0] r0_arg, r0_resparg;
    logic        r1_req, r1_gnt, r1_start, r1_busy, r1_done, r1_timeout, r1_syntaxe;
    logic [15:0] r1_precnt, r1_clkdiv;
    logic [5:0]  r1_cmd;
    logic [31:0] r1_arg, r1_resparg;
    logic        start, busy, done, timeout, syntaxe;
    logic [15:0] precnt, clkdiv;
    logic [5:0]  cmd;
    logic [31:0] arg, resparg;
    logic [1:0]  owner;
    logic        revoked, proto_err;

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [15:0] precnt;
    } start_exp_t;

    typedef struct {
        int          port;
        logic        timeout;
        logic        syntaxe;
        logic [31:0] resparg;
    } done_exp_t;

    start_exp_t start_q[$];
    done_exp_t  done_q[$];
    int         pend_port[$];

    int errors = 0;
    int checks = 0;
    int model_last = 1;
    int rev_pulses = 0;
    int eng_cnt;
    done_exp_t  eng_d;
    start_exp_t mon_s;
    done_exp_t  mon_d;

    sd_cmd_arbiter #(.PRIORITY(2), .HOLD_MAX(24'd16), .SLOWCLKDIV(SLOW)) dut (
        .clk(clk), .rstn(rstn),
        .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_start(r0_start), .r0_precnt(r0_precnt),
        .r0_cmd(r0_cmd), .r0_arg(r0_arg), .r0_clkdiv(r0_clkdiv), .r0_busy(r0_busy),
        .r0_done(r0_done), .r0_timeout(r0_timeout), .r0_syntaxe(r0_syntaxe), .r0_resparg(r0_resparg),
        .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_start(r1_start), .r1_precnt(r1_precnt),
        .r1_cmd(r1_cmd), .r1_arg(r1_arg), .r1_clkdiv(r1_clkdiv), .r1_busy(r1_busy),
        .r1_done(r1_done), .r1_timeout(r1_timeout), .r1_syntaxe(r1_syntaxe), .r1_resparg(r1_resparg),
        .start(start), .precnt(precnt), .cmd(cmd), .arg(arg), .clkdiv(clkdiv),
        .busy(busy), .done(done), .timeout(timeout), .syntaxe(syntaxe), .resparg(resparg),
        .owner(owner), .revoked(revoked), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine responder: busy one cycle after start, random length, done with random status.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            syntaxe <= 1'b0;
            resparg <= 32'd0;
            eng_cnt <= 0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            syntaxe <= 1'b0;
            if (!busy && start) begin
                busy    <= 1'b1;
                eng_cnt <= int'($urandom_range(1, 6));
                resparg <= $urandom;
            end else if (busy) begin
                if (eng_cnt == 0) begin
                    eng_d.port    = (pend_port.size() > 0) ? pend_port.pop_front() : -1;
                    eng_d.timeout = 1'($urandom_range(0, 1));
                    eng_d.syntaxe = 1'($urandom_range(0, 1));
                    eng_d.resparg = $urandom;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    timeout <= eng_d.timeout;
                    syntaxe <= eng_d.syntaxe;
                    resparg <= eng_d.resparg;
                    done_q.push_back(eng_d);
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every engine start and every delivered done is popped against the queues.
    always @(negedge clk) begin
        if (rstn) begin
            if (revoked) rev_pulses++;
            if (start) begin
                if (start_q.size() == 0) begin
                    checkOutput("start_unexpected", 64'(cmd), 64'hFFFF);
                end else begin
                    mon_s = start_q.pop_front();
                    checkOutput("start_cmd", 64'(cmd), 64'(mon_s.cmd));
                    checkOutput("start_arg", 64'(arg), 64'(mon_s.arg));
                    checkOutput("start_precnt", 64'(precnt), 64'(mon_s.precnt));
                end
            end
            if (r0_done || r1_done) begin
                if (done_q.size() == 0) begin
                    checkOutput("done_unexpected", 64'({r1_done, r0_done}), 64'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    checkOutput("done_port", 64'({r1_done, r0_done}),
                                (mon_d.port == 1) ? 64'd2 : (mon_d.port == 0) ? 64'd1 : 64'd0);
                    checkOutput("done_timeout", 64'(r1_done ? r1_timeout : r0_timeout), 64'(mon_d.timeout));
                    checkOutput("done_syntaxe", 64'(r1_done ? r1_syntaxe : r0_syntaxe), 64'(mon_d.syntaxe));
                    checkOutput("done_resparg", 64'(r1_done ? r1_resparg : r0_resparg), 64'(mon_d.resparg));
                end
            end else if (done) begin
                if (done_q.size() > 0) mon_d = done_q.pop_front();
                checkOutput("done_not_delivered", 64'({r1_done, r0_done}), 64'd3);
            end
        end
    end

    function automatic logic busy_of(input int p);
        return (p == 1) ? r1_busy : r0_busy;
    endfunction

    function automatic logic done_of(input int p);
        return (p == 1) ? r1_done : r0_done;
    endfunction

    function automatic logic gnt_of(input int p);
        return (p == 1) ? r1_gnt : r0_gnt;
    endfunction

    function automatic int modelPick(input bit q0, input bit q1, input int lastp);
        if (q0 && q1) return 1 - lastp;
        return q1 ? 1 : 0;
    endfunction

    task automatic setReq(input int p, input logic v);
        if (p == 1) r1_req = v; else r0_req = v;
    endtask

    task automatic driveStart(input int p, input logic [5:0] c, input logic [31:0] a,
                              input logic [15:0] pc, input bit drop);
        if (p == 1) begin
            r1_start = 1'b1; r1_cmd = c; r1_arg = a; r1_precnt = pc;
            if (drop) r1_req = 1'b0;
        end else begin
            r0_start = 1'b1; r0_cmd = c; r0_arg = a; r0_precnt = pc;
            if (drop) r0_req = 1'b0;
        end
    endtask

    task automatic clearStart();
        r0_start = 1'b0;
        r1_start = 1'b0;
    endtask

    // Issue one command from the owner, optionally a dropped second start while busy.
    task automatic applyStimulus(input int p, input logic [5:0] c, input logic [31:0] a,
                                 input logic [15:0] pc, input bit drop, input bit misuse);
        int n = 0;
        bit got = 1'b0;
        bit busy_ok = 1'b1;
        while (busy_of(p) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("issue_wait", 64'(busy_of(p)), 64'd0);
        driveStart(p, c, a, pc, drop);
        start_q.push_back('{c, a, pc});
        pend_port.push_back(p);
        @(negedge clk);
        clearStart();
        checkOutput("clkdiv_owned", 64'(clkdiv), 64'((p == 1) ? r1_clkdiv : r0_clkdiv));
        if (misuse) begin
            driveStart(p, ~c, ~a, pc, 1'b0);
            @(negedge clk);
            clearStart();
            checkOutput("proto_err_busy_start", 64'(proto_err), 64'd1);
        end
        for (int i = 0; i < 50 && !got; i++) begin
            if (done_of(p)) begin
                got = 1'b1;
            end else begin
                if (!busy_of(p)) busy_ok = 1'b0;
                @(negedge clk);
            end
        end
        checkOutput("busy_until_done", 64'(busy_ok), 64'd1);
        checkOutput("done_seen", 64'(got), 64'd1);
    endtask

    task automatic expectGrant(input int p);
        checkOutput("gnt_pair", 64'({r1_gnt, r0_gnt}), (p == 1) ? 64'd2 : 64'd1);
        checkOutput("owner_code", 64'(owner), 64'((p == 1) ? OWN_R1 : OWN_R0));
        checkOutput("nonowner_busy", 64'((p == 1) ? r0_busy : r1_busy), 64'd1);
        checkOutput("nonowner_resparg", 64'((p == 1) ? r0_resparg : r1_resparg), 64'd0);
    endtask

    task automatic waitRelease(input int p);
        int n = 0;
        while (gnt_of(p) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("release_gnt", 64'({r1_gnt, r0_gnt}), 64'd0);
        checkOutput("release_owner", 64'(owner), 64'(OWN_NONE));
        checkOutput("release_clkdiv", 64'(clkdiv), 64'(SLOW));
        model_last = p;
    endtask

    task automatic waitOwnerNone();
        int n = 0;
        while (owner != OWN_NONE && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", 64'(owner), 64'(OWN_NONE));
    endtask

    task automatic runOwner(input int p);
        int  n;
        bit  drop;
        bit  dropped = 1'b0;
        n = int'($urandom_range(1, 3));
        for (int k = 0; k < n; k++) begin
            drop = (k == n - 1) && ($urandom_range(0, 1) == 1);
            applyStimulus(p, 6'($urandom), $urandom, 16'($urandom), drop, 1'b0);
            if (drop) dropped = 1'b1;
        end
        if (!dropped) setReq(p, 1'b0);
        waitRelease(p);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_gnt"}, 64'({r1_gnt, r0_gnt}), 64'd0);
        checkOutput({tag, "_start"}, 64'(start), 64'd0);
        checkOutput({tag, "_precnt"}, 64'(precnt), 64'd0);
        checkOutput({tag, "_cmd"}, 64'(cmd), 64'd0);
        checkOutput({tag, "_arg"}, 64'(arg), 64'd0);
        checkOutput({tag, "_clkdiv"}, 64'(clkdiv), 64'(SLOW));
        checkOutput({tag, "_owner"}, 64'(owner), 64'(OWN_NONE));
        checkOutput({tag, "_revoked"}, 64'(revoked), 64'd0);
        checkOutput({tag, "_proto_err"}, 64'(proto_err), 64'd0);
    endtask

    initial begin
        int first_rev;
        rstn = 1'b0;
        r0_req = 0; r0_start = 0; r0_precnt = 0; r0_cmd = 0; r0_arg = 0; r0_clkdiv = 16'd4;
        r1_req = 0; r1_start = 0; r1_precnt = 0; r1_cmd = 0; r1_arg = 0; r1_clkdiv = 16'd8;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Single owner with a CMD13 poll and a couple of random commands.
        r1_req = 1'b1;
        checkOutput("gnt_latency", 64'(r1_gnt), 64'd0);
        @(negedge clk);
        expectGrant(1);
        applyStimulus(1, CMD13, 32'h0001_0000, 16'($urandom), 1'b0, 1'b0);
        applyStimulus(1, 6'($urandom), $urandom, 16'($urandom), 1'b0, 1'b0);
        r1_req = 1'b0;
        waitRelease(1);

        // Simultaneous requests: round-robin after port 1 picks port 0; port 1 misuses.
        @(negedge clk);
        r0_clkdiv = 16'($urandom_range(1, 500));
        r0_req = 1'b1;
        r1_req = 1'b1;
        @(negedge clk);
        expectGrant(modelPick(1'b1, 1'b1, model_last));
        r1_start = 1'b1;
        r1_cmd = CMD13;
        @(negedge clk);
        r1_start = 1'b0;
        checkOutput("proto_err_nonowner", 64'(proto_err), 64'd1);
        applyStimulus(0, CMD13, $urandom, 16'($urandom), 1'b0, 1'b0);
        r0_req = 1'b0;
        waitRelease(0);
        @(negedge clk);
        expectGrant(1);
        applyStimulus(1, CMD13, $urandom, 16'($urandom), 1'b0, 1'b0);
        r1_req = 1'b0;
        waitRelease(1);

        // Request dropped together with a CMD24 start: grant held until done.
        @(negedge clk);
        r1_req = 1'b1;
        @(negedge clk);
        expectGrant(1);
        applyStimulus(1, CMD24, $urandom, 16'($urandom), 1'b1, 1'b0);
        checkOutput("gnt_held_for_done", 64'(r1_gnt), 64'd1);
        waitRelease(1);
        checkOutput("proto_err_sticky", 64'(proto_err), 64'd1);

        // Hold limit: idle owner is revoked after 16 idle cycles, pending port wins.
        @(negedge clk);
        r1_req = 1'b1;
        @(negedge clk);
        expectGrant(1);
        r0_req = 1'b1;
        first_rev = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (revoked && first_rev == 0) first_rev = i;
        end
        checkOutput("revoke_cycle", 64'(first_rev), 64'd16);
        @(negedge clk);
        checkOutput("revoke_single", 64'(revoked), 64'd0);
        checkOutput("revoke_gnt_drop", 64'({r1_gnt, r0_gnt}), 64'd0);
        model_last = 1;
        @(negedge clk);
        expectGrant(modelPick(1'b1, 1'b1, model_last));
        r1_req = 1'b0;
        applyStimulus(0, 6'($urandom), $urandom, 16'($urandom), 1'b0, 1'b0);

        // Asynchronous reset while a forwarded start is in flight.
        driveStart(0, CMD24, $urandom, 16'($urandom), 1'b0);
        start_q.push_back('{r0_cmd, r0_arg, r0_precnt});
        pend_port.push_back(0);
        @(negedge clk);
        clearStart();
        checkOutput("pre_reset_start", 64'(start), 64'd1);
        #1 rstn = 1'b0;
        #1 checkResetValues("async_reset");
        start_q.delete();
        done_q.delete();
        pend_port.delete();
        r0_req = 1'b0;
        model_last = 1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        r1_req = 1'b1;
        @(negedge clk);
        expectGrant(1);
        applyStimulus(1, CMD13, $urandom, 16'($urandom), 1'b0, 1'b1);
        r1_req = 1'b0;
        waitRelease(1);

        // Random sessions against the round-robin ownership model.
        for (int it = 0; it < 12; it++) begin
            int mask;
            int win;
            waitOwnerNone();
            @(negedge clk);
            mask = int'($urandom_range(1, 3));
            r0_clkdiv = 16'($urandom_range(1, 500));
            r1_clkdiv = 16'($urandom_range(1, 500));
            win = modelPick(mask[0], mask[1], model_last);
            r0_req = mask[0];
            r1_req = mask[1];
            @(negedge clk);
            expectGrant(win);
            runOwner(win);
            if (mask == 3) begin
                @(negedge clk);
                expectGrant(1 - win);
                runOwner(1 - win);
            end
        end

        repeat (4) @(negedge clk);
        checkOutput("start_q_empty", 64'(start_q.size()), 64'd0);
        checkOutput("done_q_empty", 64'(done_q.size()), 64'd0);
        checkOutput("revoke_total", 64'(rev_pulses), 64'd1);
        checkOutput("proto_err_final", 64'(proto_err), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_arbiter.md
Name: sd_cmd_arbiter

Overview:
- Shares the single SD command engine (start/precnt/cmd/arg/clkdiv in; busy/done/timeout/syntaxe/resparg out) between two requesters: port 0 = sector reader/initialiser, port 1 = sector writer.
- A requester holds ownership with a level request across a whole command sequence, e.g. CMD13 polling → CMD24 → CMD13 polling.
- The arbiter forwards only the owner's commands.
  - It shields the non-owner by reporting busy to it.
  - It polices protocol misuse and enforces an ownership hold limit.
- Sits between the two host FSMs and the SD command engine, inside the SD card top.

Parameters:
- PRIORITY, 0: tie-break when both request while idle. 0 = port 0 wins, 1 = port 1 wins, 2 = round-robin (the port not granted last time wins).
- HOLD_MAX, 24'd4000000: idle clk cycles an owner may hold the grant without issuing a start before forced revocation. 0 disables the limit.
- SLOWCLKDIV, 16'd192: clkdiv driven to the engine while no port owns it.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- rN_req  in  1  (N=0,1) ownership request, level
- rN_gnt  out  1  ownership granted
- rN_start  in  1  command start pulse from requester
- rN_precnt  in  16  pre-command idle count
- rN_cmd  in  6  command index
- rN_arg  in  32  command argument
- rN_clkdiv  in  16  requested SD clock divider
- rN_busy  out  1  engine busy as seen by requester
- rN_done  out  1  command finished pulse
- rN_timeout  out  1  response timeout (valid with done)
- rN_syntaxe  out  1  response syntax error (valid with done)
- rN_resparg  out  32  response argument
- start  out  1  to engine
- precnt  out  16  to engine
- cmd  out  6  to engine
- arg  out  32  to engine
- clkdiv  out  16  to engine
- busy  in  1  from engine
- done  in  1  from engine
- timeout  in  1  from engine
- syntaxe  in  1  from engine
- resparg  in  32  from engine
- owner  out  2  2'b00 none, 2'b01 port 0, 2'b10 port 1
- revoked  out  1  one-cycle pulse on forced release
- proto_err  out  1  sticky, cleared only by reset

Behaviour:
- Reset values:
  - r0_gnt=r1_gnt=0, start=0, precnt=0, cmd=0, arg=0.
  - clkdiv=SLOWCLKDIV, owner=0, revoked=0, proto_err=0.
  - FSM=IDLE, hold counter=0, inflight=0, last-granted=port 1.
- FSM states: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - Any rN_req high → OWNn on the next edge, resolved per PRIORITY. rN_gnt and owner are registered, so grant latency is 1 cycle.
  - Starts arriving in IDLE are dropped and set proto_err.
- OWNn, forwarding:
  - start is a 1-cycle pulse on the edge after rn_start, if the engine is idle. Idle means busy=0 and inflight=0.
  - precnt/cmd/arg latch on the same edge. clkdiv <= rn_clkdiv every cycle while owned.
  - inflight is set with the forwarded start and cleared when busy=1 or done=1 is seen.
- OWNn, requester view:
  - owner sees rn_busy = busy | start | inflight, so no double-issue in the 2-cycle gap.
  - rn_done/timeout/syntaxe = engine signals ANDed with ownership.
  - rn_resparg = resparg, live and unregistered; the writer samples it mid-busy.
  - non-owner sees busy=1, done=0, timeout=0, syntaxe=0, resparg=0.
- OWNn, protocol errors:
  - rn_start while the owner's busy is high is dropped and sets proto_err.
  - A non-owner start is dropped and sets proto_err.
- OWNn, release:
  - rn_req low → DRAIN.
  - The hold counter increments each cycle the engine is idle and no start occurs, and resets on a forwarded start.
  - Counter == HOLD_MAX (nonzero) → DRAIN with revoked pulsed once.
- DRAIN:
  - Waits until busy=0 and inflight=0, then → IDLE.
  - gnt stays asserted through DRAIN so the final done is still delivered.
  - gnt drops on the IDLE transition edge; last-granted is updated.
  - A start in DRAIN is dropped and sets proto_err.
- Simultaneous events:
  - req drop and start in the same cycle: the start is forwarded, then DRAIN.
  - Both requests rise together in IDLE: PRIORITY decides; the loser waits.
- Back-to-back ownership: minimum 1 idle cycle in IDLE between owners. The same port may be re-granted immediately only if the other port is not requesting.
- Reset mid-command: all outputs return to reset values immediately. The engine is reset by the same rstn.

Decomposition:
- Shared package sd_pkg holds:
  - owner encodings (OWN_NONE/OWN_R0/OWN_R1);
  - PRIORITY codes;
  - FSM state localparams;
  - SD command indices CMD13=6'd13, CMD24=6'd24.
- One natural sub-module: sd_cmd_arb_pick, the combinational priority/round-robin selector (req[1:0], last, PRIORITY → grant index).

Test Plan:
- Single owner: r1_req=1 → r1_gnt=1 one cycle later. r1_start with cmd=13, arg=32'h0001_0000 → start pulse the next cycle with matching cmd/arg. r1_busy stays high until the engine's done; r1_done pulses exactly once.
- Contention: r0_req and r1_req rise in the same cycle with PRIORITY=2 and last=1 → port 0 granted. Port 0 releases → after DRAIN plus 1 IDLE cycle, port 1 is granted.
- Release mid-command: r1 forwards a CMD24 start and drops req in the same cycle → start forwarded, gnt held until busy falls, r1_done delivered, then owner=0 and clkdiv=SLOWCLKDIV.
- Misuse:
  - r0_start while port 1 owns → no engine start, proto_err=1 and stays 1.
  - owner start while busy=1 → dropped.
- Hold limit: HOLD_MAX=16, owner idle with no start → revoked pulses on the 16th idle cycle, gnt drops, and the other pending requester is granted.
- Reset mid-command: rstn low while start/inflight set → all outputs equal reset values asynchronously. After release, a clean grant works.
